const_div_iter: RTL and testbench
=================================

# const_div_iter

Iterative unsigned divide-by-constant unit: divides a WIDTH-bit operand by a compile-time DIVISOR, retiring DIGIT_W quotient bits per clock, MSB-first, with a carried remainder. It is the parametrised, sequential successor of the fixed 64-bit divide-by-3 remainder tables. It trades latency for area: one digit-step table is reused across WIDTH/DIGIT_W cycles. It sits between operand producers and consumers via valid/ready handshakes.

## Interface
- WIDTH, 64: operand and quotient width. Must be a multiple of DIGIT_W.
- DIVISOR, 3: constant divisor, ≥2, any value (power of two permitted).
- DIGIT_W, 4: bits consumed per cycle, 1..8.
- REM_W (derived, localparam): clog2(DIVISOR).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  unit idle and able to accept.
- in_data  in  WIDTH  dividend, unsigned.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- out_quot  out  WIDTH  floor(in_data / DIVISOR).
- out_rem  out  REM_W  in_data mod DIVISOR. Present only with CONST_DIV_REM_EN.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: load in_data into the shift register, clear remainder to 0, clear digit counter, go to RUN.
- RUN, each cycle:
  - Take the top DIGIT_W bits of the shift register as d.
  - Compute t = rem·2^DIGIT_W + d, qd = t / DIVISOR, rem = t mod DIVISOR.
  - Shift qd into the quotient LSBs and shift the operand left by DIGIT_W.
  - Increment the counter. After K = WIDTH/DIGIT_W steps, go to DONE.
- DONE:
  - out_valid=1; out_quot/out_rem stable.
  - On out_ready, go to IDLE.
- Arithmetic rules:
  - t < DIVISOR·2^DIGIT_W, so qd always fits DIGIT_W bits. This is an invariant; assert it in simulation.
  - rem < DIVISOR always.
  - Counter width is clog2(K+1).
- in_ready is 0 outside IDLE. in_valid in RUN/DONE is ignored and not captured.
- Reset mid-operation: abort immediately. The result is discarded, nothing is emitted, and the state returns to IDLE.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0
  - out_quot=0
  - out_rem=0
  - busy=0
- Acceptance at rising edge E0 (in_valid&&in_ready). out_valid rises after edge E0+K, i.e. latency K cycles. For the defaults, K=16.
- out_valid stays high with outputs stable until the edge where out_ready=1. It drops after that edge; in_ready rises at the same edge.
- Minimum initiation interval K+2 cycles with out_ready tied high.
- out_quot/out_rem are registered and change only at the DONE-entry edge. They hold their last value in IDLE.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

## Configuration
- CONST_DIV_REM_EN defined:
  - out_rem port exists.
  - The final remainder register drives it.
- CONST_DIV_REM_EN undefined:
  - out_rem port is absent.
  - The remainder is still kept internally for the recurrence, but no output register exists.
  - Quotient behaviour is identical.

## Structure
- Package const_div_pkg holds:
  - state enum (IDLE/RUN/DONE)
  - clog2 helper function
  - compile-time parameter checks (WIDTH%DIGIT_W==0, DIVISOR≥2, DIGIT_W≤8)
- Sub-module const_div_step is purely combinational, parametrised by DIVISOR and DIGIT_W.
  - Inputs: rem_in[REM_W], digit[DIGIT_W].
  - Outputs: qd[DIGIT_W], rem_out[REM_W].
  - It is the generalised form of the existing 6-input divide-by-3 table (REM_W=2, DIGIT_W=4).
- The top module holds the FSM, counter, shift registers and handshake.

## Test plan
- Defaults, in_data=100 → out_quot=33, out_rem=1. out_valid asserted exactly 16 cycles after acceptance.
- Defaults, in_data=0xFFFF_FFFF_FFFF_FFFF → out_quot=0x5555_5555_5555_5555, out_rem=0. in_data=0 → 0 / 0.
- WIDTH=32, DIVISOR=7, DIGIT_W=8, in_data=1000 → out_quot=142, out_rem=6, latency 4.
- Backpressure: out_ready low for 5 cycles in DONE → outputs stable, in_ready=0, and an in_valid pulse during this window is not captured. The unit accepts the next operand only after the handshake.
- rst pulsed 7 cycles into RUN → out_valid never rises, in_ready=1 next cycle. The following operand 9 (defaults) → out_quot=3, out_rem=0.
- Random regression over 10k operands per configuration, checked against a reference model of /DIVISOR and %DIVISOR. Also checked with CONST_DIV_REM_EN undefined, quotient only.

Source files
------------

// File: rtl/const_div_pkg.sv
// Shared types and elaboration-time helpers for the iterative divide-by-constant unit.
// No logic; imported by const_div_step and const_div_iter.
// Holds the FSM state encoding, a ceiling-log2 helper and the parameter legality check.
package const_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2: number of bits needed to hold the values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Legal configurations: whole digits per operand, nontrivial divisor, digit 1..8 bits.
  function automatic bit params_ok(input int width, input int divisor, input int digit_w);
    return (digit_w >= 1) && (digit_w <= 8) && (divisor >= 2) &&
           (width > 0) && ((width % digit_w) == 0);
  endfunction

endpackage

// File: rtl/const_div_step.sv
// One digit step of the long division: {rem_in, digit} / DIVISOR -> qd, rem_out.
// Purely combinational, zero latency, no handshake.
// Generalises the old 6-input divide-by-3 table; synthesis folds the constant divide.
module const_div_step
  import const_div_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int DIGIT_W = 4
) (
  input  logic [clog2(DIVISOR)-1:0] rem_in,
  input  logic [DIGIT_W-1:0]        digit,
  output logic [DIGIT_W-1:0]        qd,
  output logic [clog2(DIVISOR)-1:0] rem_out
);

  localparam int REM_W = clog2(DIVISOR);
  localparam int TW    = REM_W + DIGIT_W;

  logic [TW-1:0] t;

  // t = rem_in * 2^DIGIT_W + digit; since rem_in < DIVISOR the quotient fits DIGIT_W bits.
  assign t       = {rem_in, digit};
  assign qd      = DIGIT_W'(t / TW'(DIVISOR));
  assign rem_out = REM_W'(t % TW'(DIVISOR));

endmodule

// File: rtl/const_div_iter.sv
// Iterative unsigned WIDTH/DIVISOR, DIGIT_W quotient bits per cycle MSB-first (out_rem with CONST_DIV_REM_EN).
// Latency WIDTH/DIGIT_W cycles from acceptance to out_valid; initiation interval K+2.
// Result held in DONE until out_ready; in_ready low (and in_valid ignored) outside IDLE.
module const_div_iter
  import const_div_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int DIVISOR = 3,
  parameter int DIGIT_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_quot,
`ifdef CONST_DIV_REM_EN
  output logic [clog2(DIVISOR)-1:0] out_rem,
`endif
  output logic                      busy
);

  localparam int REM_W = clog2(DIVISOR);
  localparam int K     = WIDTH / DIGIT_W;
  localparam int CW    = clog2(K + 1);
  localparam int TW    = REM_W + DIGIT_W;

  generate
    if (!params_ok(WIDTH, DIVISOR, DIGIT_W)) begin : g_bad_params
      $error("const_div_iter: illegal WIDTH/DIVISOR/DIGIT_W combination");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] quot;
  logic [REM_W-1:0] rem;
  logic [CW-1:0]    cnt;

  logic [DIGIT_W-1:0] digit;
  logic [DIGIT_W-1:0] qd;
  logic [REM_W-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quot_nxt;
  logic [TW-1:0]      t_chk;

  assign digit    = opnd[WIDTH-1 -: DIGIT_W];
  assign quot_nxt = (quot << DIGIT_W) | WIDTH'(qd);
  assign t_chk    = {rem, digit};

  const_div_step #(
    .DIVISOR (DIVISOR),
    .DIGIT_W (DIGIT_W)
  ) u_step (
    .rem_in  (rem),
    .digit   (digit),
    .qd      (qd),
    .rem_out (rem_nxt)
  );

  // FSM, datapath shift registers and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      opnd      <= '0;
      quot      <= '0;
      rem       <= '0;
      cnt       <= '0;
      out_quot  <= '0;
`ifdef CONST_DIV_REM_EN
      out_rem   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd     <= in_data;
            quot     <= '0;
            rem      <= '0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          opnd <= opnd << DIGIT_W;
          quot <= quot_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt + 1'b1;
          // Last digit: the result registers load straight from the step output.
          if (cnt == CW'(K - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_quot  <= quot_nxt;
`ifdef CONST_DIV_REM_EN
            out_rem   <= rem_nxt;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Recurrence invariants: each step quotient fits a digit, and rem stays below DIVISOR.
  a_qd_fits: assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> (((t_chk / TW'(DIVISOR)) >> DIGIT_W) == TW'(0)));
  a_rem_lt: assert property (@(posedge clk) disable iff (rst)
    (TW'(rem) < TW'(DIVISOR)));

endmodule

// File: tb/tb_const_div_iter.sv
// Directed table-driven bench for const_div_iter: default config and WIDTH=32/DIVISOR=7/DIGIT_W=8.
// Adds backpressure, mid-run reset and a short random sweep against native / and %.
// out_rem is checked only when CONST_DIV_REM_EN is defined.
module tb_const_div_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: defaults (64 / 3 / 4)
  logic        vld_a = 1'b0, ordy_a = 1'b0;
  logic [63:0] din_a = '0;
  logic        rdy_a, ovld_a, busy_a;
  logic [63:0] quot_a;
  logic [1:0]  rem_a;

  // Instance B: 32 / 7 / 8
  logic        vld_b = 1'b0, ordy_b = 1'b0;
  logic [31:0] din_b = '0;
  logic        rdy_b, ovld_b, busy_b;
  logic [31:0] quot_b;
  logic [2:0]  rem_b;

  const_div_iter u_dut (
    .clk(clk), .rst(rst), .in_valid(vld_a), .in_ready(rdy_a), .in_data(din_a),
    .out_valid(ovld_a), .out_ready(ordy_a), .out_quot(quot_a),
`ifdef CONST_DIV_REM_EN
    .out_rem(rem_a),
`endif
    .busy(busy_a)
  );

  const_div_iter #(.WIDTH(32), .DIVISOR(7), .DIGIT_W(8)) u_dut7 (
    .clk(clk), .rst(rst), .in_valid(vld_b), .in_ready(rdy_b), .in_data(din_b),
    .out_valid(ovld_b), .out_ready(ordy_b), .out_quot(quot_b),
`ifdef CONST_DIV_REM_EN
    .out_rem(rem_b),
`endif
    .busy(busy_b)
  );

`ifndef CONST_DIV_REM_EN
  assign rem_a = '0;
  assign rem_b = '0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_a(input logic [63:0] din, output logic [63:0] q, output logic [1:0] r,
                       output int lat);
    int w;
    w = 0;
    while (!rdy_a && w < 50) begin @(posedge clk); #1; w++; end
    vld_a = 1'b1; din_a = din;
    @(posedge clk); #1;
    vld_a = 1'b0;
    lat = 0;
    while (!ovld_a && lat < 100) begin @(posedge clk); #1; lat++; end
    q = quot_a; r = rem_a;
    ordy_a = 1'b1;
    @(posedge clk); #1;
    ordy_a = 1'b0;
  endtask

  task automatic run_b(input logic [31:0] din, output logic [31:0] q, output logic [2:0] r,
                       output int lat);
    int w;
    w = 0;
    while (!rdy_b && w < 50) begin @(posedge clk); #1; w++; end
    vld_b = 1'b1; din_b = din;
    @(posedge clk); #1;
    vld_b = 1'b0;
    lat = 0;
    while (!ovld_b && lat < 100) begin @(posedge clk); #1; lat++; end
    q = quot_b; r = rem_b;
    ordy_b = 1'b1;
    @(posedge clk); #1;
    ordy_b = 1'b0;
  endtask

  typedef struct {
    logic [63:0] din;
    logic [63:0] quot;
    logic [2:0]  rem;
  } vec_t;

  vec_t va [8];
  vec_t vb [7];

  initial begin
    logic [63:0] qa, ra64;
    logic [1:0]  ra;
    logic [31:0] qb, xb;
    logic [2:0]  rb;
    logic [63:0] xa;
    int lat;
    int cyc;

    va[0] = '{64'd100,                   64'd33,                    3'd1};
    va[1] = '{64'hFFFF_FFFF_FFFF_FFFF,   64'h5555_5555_5555_5555,   3'd0};
    va[2] = '{64'd0,                     64'd0,                     3'd0};
    va[3] = '{64'd9,                     64'd3,                     3'd0};
    va[4] = '{64'd1,                     64'd0,                     3'd1};
    va[5] = '{64'd2,                     64'd0,                     3'd2};
    va[6] = '{64'h8000_0000_0000_0000,   64'h2AAA_AAAA_AAAA_AAAA,   3'd2};
    va[7] = '{64'd12345678901,           64'd4115226300,            3'd1};

    vb[0] = '{64'd1000,       64'd142,       3'd6};
    vb[1] = '{64'd0,          64'd0,         3'd0};
    vb[2] = '{64'hFFFF_FFFF,  64'd613566756, 3'd3};
    vb[3] = '{64'd6,          64'd0,         3'd6};
    vb[4] = '{64'd7,          64'd1,         3'd0};
    vb[5] = '{64'd255,        64'd36,        3'd3};
    vb[6] = '{64'd256,        64'd36,        3'd4};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  rdy_a,  1'b1);
    chk("rst_out_valid", ovld_a, 1'b0);
    chk("rst_out_quot",  quot_a, 64'd0);
    chk("rst_busy",      busy_a, 1'b0);
`ifdef CONST_DIV_REM_EN
    chk("rst_out_rem",   rem_a,  2'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, default configuration
    for (int i = 0; i < 8; i++) begin
      run_a(va[i].din, qa, ra, lat);
      chk($sformatf("a_quot[%0d]", i), qa, va[i].quot);
`ifdef CONST_DIV_REM_EN
      chk($sformatf("a_rem[%0d]", i), ra, va[i].rem[1:0]);
`endif
      chk($sformatf("a_lat[%0d]", i), lat, 16);
    end

    // Directed vectors, 32/7/8
    for (int i = 0; i < 7; i++) begin
      run_b(vb[i].din[31:0], qb, rb, lat);
      chk($sformatf("b_quot[%0d]", i), qb, vb[i].quot);
`ifdef CONST_DIV_REM_EN
      chk($sformatf("b_rem[%0d]", i), rb, vb[i].rem);
`endif
      chk($sformatf("b_lat[%0d]", i), lat, 4);
    end

    // Backpressure: result held 5 cycles, in_valid pulse in DONE ignored
    vld_a = 1'b1; din_a = 64'd100;
    @(posedge clk); #1;
    vld_a = 1'b0;
    cyc = 0;
    while (!ovld_a && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("bp_enter_done", ovld_a, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid[%0d]", c), ovld_a, 1'b1);
      chk($sformatf("bp_in_ready[%0d]", c), rdy_a, 1'b0);
      chk($sformatf("bp_quot[%0d]", c), quot_a, 64'd33);
      vld_a = (c == 2); din_a = 64'd50;
      @(posedge clk); #1;
    end
    vld_a = 1'b0;
    ordy_a = 1'b1;
    @(posedge clk); #1;
    ordy_a = 1'b0;
    chk("bp_valid_drop", ovld_a, 1'b0);
    chk("bp_in_ready_up", rdy_a, 1'b1);
    chk("bp_hold_quot", quot_a, 64'd33);
    @(posedge clk); #1;
    chk("bp_not_captured", busy_a, 1'b0);
    run_a(64'd50, qa, ra, lat);
    chk("bp_next_quot", qa, 64'd16);
`ifdef CONST_DIV_REM_EN
    chk("bp_next_rem", ra, 2'd2);
`endif

    // Reset 7 cycles into RUN aborts the operation
    vld_a = 1'b1; din_a = 64'd100;
    @(posedge clk); #1;
    vld_a = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mr_busy_before", busy_a, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_in_ready", rdy_a, 1'b1);
    chk("mr_busy", busy_a, 1'b0);
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      if (ovld_a) cyc++;
      @(posedge clk); #1;
    end
    chk("mr_no_valid", cyc, 0);
    run_a(64'd9, qa, ra, lat);
    chk("mr_next_quot", qa, 64'd3);
`ifdef CONST_DIV_REM_EN
    chk("mr_next_rem", ra, 2'd0);
`endif

    // Random sweep against native division
    for (int i = 0; i < 300; i++) begin
      xa = (i % 4 == 0) ? 64'($urandom_range(0, 1000)) : {$urandom, $urandom};
      run_a(xa, qa, ra, lat);
      chk("rnd_a_quot", qa, xa / 64'd3);
      ra64 = xa % 64'd3;
`ifdef CONST_DIV_REM_EN
      chk("rnd_a_rem", ra, ra64[1:0]);
`endif
    end
    for (int i = 0; i < 300; i++) begin
      xb = (i % 4 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      run_b(xb, qb, rb, lat);
      chk("rnd_b_quot", qb, xb / 32'd7);
`ifdef CONST_DIV_REM_EN
      chk("rnd_b_rem", rb, 3'(xb % 32'd7));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
